// File: rtl/ex_div.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU in the execute stage.
// Returns {remainder, quotient} after 33 edges; stalls the pipeline while busy.
module ex_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stallreq_o
);

   typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic [32:0] shifted;
   logic [32:0] trial;
   logic [31:0] quot_n;
   logic [31:0] rem_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= FREE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   always_comb begin
      // One restoring step: a clear borrow bit means the trial difference is kept.
      shifted  = {rem_q, dvd_q[31]};
      trial    = shifted - {1'b0, dvs_q};
      quot_n   = {dvd_q[30:0], ~trial[32]};
      rem_n    = trial[32] ? shifted[31:0] : trial[31:0];

      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      ready_d  = ready_q;

      unique case (state_q)
         FREE: begin
            ready_d  = 1'b0;
            result_d = '0;
            if (start_i && !annul_i) begin
               if (opdata2_i == 32'd0) begin
                  state_d = BY_ZERO;
               end else begin
                  state_d = ON;
                  cnt_d   = '0;
                  rem_d   = '0;
                  dvd_d   = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
                  dvs_d   = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
                  negq_d  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                  negr_d  = signed_div_i & opdata1_i[31];
               end
            end
         end
         BY_ZERO: begin
            result_d = '0;
            if (annul_i) begin
               state_d = FREE;
               ready_d = 1'b0;
            end else begin
               state_d = END;
               ready_d = 1'b1;
            end
         end
         ON: begin
            if (annul_i) begin
               state_d  = FREE;
               ready_d  = 1'b0;
               result_d = '0;
            end else begin
               rem_d = rem_n;
               dvd_d = quot_n;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d  = END;
                  ready_d  = 1'b1;
                  result_d = {negr_q ? -rem_n : rem_n, negq_q ? -quot_n : quot_n};
               end
            end
         end
         END: begin
            if (!start_i || annul_i) begin
               state_d  = FREE;
               ready_d  = 1'b0;
               result_d = '0;
            end
         end
         default: state_d = FREE;
      endcase
   end

   always_comb begin
      result_o   = result_q;
      ready_o    = ready_q;
      stallreq_o = start_i & ~ready_q & ~annul_i;
   end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: table of divisions plus annul and async-reset sequences.
module tb_ex_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   ex_div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply a request and count edges until ready; operands are scrambled after the accept edge.
   task automatic run_vec(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat, output logic stall_bad);
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      lat          = 0;
      stall_bad    = 1'b0;
      #1;
      if (!stallreq_o) stall_bad = 1'b1;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) begin
            opdata1_i = ~a;
            opdata2_i = b + 32'd3;
         end
         if (ready_o) break;
         if (!stallreq_o) stall_bad = 1'b1;
      end
      res = result_o;
   endtask

   task automatic finish_op(input string name, input logic [63:0] exp);
      chk({name, "_stall_at_ready"}, 64'(stallreq_o), 64'd0);
      @(posedge clk);
      #1;
      chk({name, "_hold_ready"}, 64'(ready_o), 64'd1);
      chk({name, "_hold_result"}, result_o, exp);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({name, "_drop_ready"}, 64'(ready_o), 64'd0);
      chk({name, "_drop_result"}, result_o, 64'd0);
   endtask

   initial begin
      logic [63:0] res;
      int          lat;
      logic        sbad;
      logic        seen;

      vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
      vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 33};
      vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
      vecs[3] = '{1'b0, 32'd1234,       32'd0,        64'h00000000_00000000, 2};
      vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
      vecs[5] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33};
      vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'h10,       64'h0000000F_0FFFFFFF, 33};
      vecs[7] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33};
      vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33};
      vecs[9] = '{1'b1, 32'hFFFFFFF9,   32'd0,        64'h00000000_00000000, 2};

      rst          = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 64'(ready_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      chk("reset_stall", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat, sbad);
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d_result", i), res, vecs[i].exp);
         chk($sformatf("v%0d_stall_busy", i), 64'(sbad), 64'd0);
         finish_op($sformatf("v%0d", i), vecs[i].exp);
      end

      // Annul after 10 iterations: no result may ever appear.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      chk("annul_busy_stall", 64'(stallreq_o), 64'd1);
      @(negedge clk);
      annul_i = 1'b1;
      #1;
      chk("annul_stall_comb", 64'(stallreq_o), 64'd0);
      @(posedge clk);
      #1;
      chk("annul_ready", 64'(ready_o), 64'd0);
      chk("annul_result", result_o, 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready_o) seen = 1'b1;
      end
      chk("annul_no_ready", 64'(seen), 64'd0);
      run_vec(1'b0, 32'hFFFFFFFF, 32'h10, res, lat, sbad);
      chk("post_annul_latency", 64'(lat), 64'd33);
      chk("post_annul_result", res, 64'h0000000F_0FFFFFFF);
      finish_op("post_annul", 64'h0000000F_0FFFFFFF);

      // Async reset at iteration 20, away from any clock edge.
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      repeat (21) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_mid_ready", 64'(ready_o), 64'd0);
      chk("rst_mid_result", result_o, 64'd0);
      chk("rst_mid_stall", 64'(stallreq_o), 64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b1;
      run_vec(1'b0, 32'd100, 32'd7, res, lat, sbad);
      chk("post_rst_latency", 64'(lat), 64'd33);
      chk("post_rst_result", res, 64'h00000002_0000000E);

      // Async reset while holding a finished result.
      #2;
      rst = 1'b0;
      #1;
      chk("rst_end_ready", 64'(ready_o), 64'd0);
      chk("rst_end_result", result_o, 64'd0);
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b1;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
